// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron layer sequencer.
// FSM state encoding plus a constant-foldable clog2 helper.
package perceptron_pkg;

  localparam int N_BITS       = 32;
  localparam int MNIST_INPUTS = 784;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FETCH,
    LOAD,
    STREAM,
    WAIT_DONE,
    DRAIN
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/perceptron_layer_sequencer_if.sv
// Stream bundle between the sequencer, the neuron bank and the next layer.
// x_* is the broadcast input stream, m_* the activation output stream.
interface perceptron_layer_sequencer_if #(
  parameter int DW = 32,
  parameter int NN = 10
);

  logic [DW-1:0] x_tdata;
  logic          x_tvalid;
  logic [NN-1:0] x_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;

  modport master (
    output x_tdata, x_tvalid,
    input  x_tready,
    output m_tdata, m_tvalid, m_tlast,
    input  m_tready
  );

  modport slave (
    input  x_tdata, x_tvalid,
    output x_tready,
    input  m_tdata, m_tvalid, m_tlast,
    output m_tready
  );

endinterface

// File: rtl/act_out_buffer.sv
// Activation snapshot with AXI-Stream read-out.
// Loads all neuron outputs at once, then drains them in index order.
module act_out_buffer #(
  parameter int N_NEURONS = 10,
  parameter int N_BITS    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [N_NEURONS*N_BITS-1:0] nrn_a,
  input  logic                        valid,
  input  logic                        m_tready,
  output logic [N_BITS-1:0]           m_tdata,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  output logic                        last_beat
);
  import perceptron_pkg::*;

  localparam int OW = (N_NEURONS > 1) ? clog2(N_NEURONS) : 1;

  logic [N_BITS-1:0] mem [N_NEURONS];
  logic [OW-1:0]     oidx;
  logic              last;

  assign last      = oidx == OW'(N_NEURONS - 1);
  assign m_tvalid  = valid;
  assign m_tdata   = valid ? mem[oidx] : '0;
  assign m_tlast   = valid & last;
  assign last_beat = valid & m_tready & last;

  // Snapshot every neuron's activation in one cycle
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        mem[i] <= nrn_a[i*N_BITS +: N_BITS];
      end
    end
  end

  // Read-out index advances only on an accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oidx <= '0;
    end else if (load) begin
      oidx <= '0;
    end else if (valid && m_tready) begin
      oidx <= last ? '0 : oidx + 1'b1;
    end
  end

endmodule

// File: rtl/perceptron_layer_sequencer.sv
// Runs one fully-connected layer: restart bank, broadcast inputs,
// collect activations and stream them out with tlast.
module perceptron_layer_sequencer #(
  parameter int N_INPUTS     = perceptron_pkg::MNIST_INPUTS,
  parameter int N_NEURONS    = 10,
  parameter int N_BITS       = perceptron_pkg::N_BITS,
  parameter int ADDR_W       = 10,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic                        go,
  input  logic                        abort,
  output logic                        busy,
  output logic                        layer_done,
  output logic                        err_timeout,
  output logic [ADDR_W-1:0]           in_addr,
  input  logic [N_BITS-1:0]           in_rdata,
  output logic                        nrn_start,
  input  logic [N_NEURONS-1:0]        nrn_done,
  input  logic [N_NEURONS*N_BITS-1:0] nrn_a,
  perceptron_layer_sequencer_if.master bus
);
  import perceptron_pkg::*;

  localparam int TW = clog2(DONE_TIMEOUT + 1);

  state_t        state, nxt;
  logic [ADDR_W-1:0] idx;
  logic [TW-1:0] tcnt;
  logic          st_cnt;
  logic          accept, last_in, all_done;
  logic          tmo, last_beat, load, drain;

  assign accept    = bus.x_tvalid & (&bus.x_tready);
  assign last_in   = idx == ADDR_W'(N_INPUTS - 1);
  assign all_done  = &nrn_done;
  assign tmo       = (tcnt + 1'b1) == TW'(DONE_TIMEOUT);
  assign drain     = state == DRAIN;
  assign load      = (state == WAIT_DONE) & all_done & ~abort;

  assign busy         = state != IDLE;
  assign nrn_start    = state == START;
  assign bus.x_tvalid = state == STREAM;
  assign in_addr      = idx;

  // State register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= nxt;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (go) nxt = START;
      START:     if (st_cnt) nxt = FETCH;
      FETCH:     nxt = LOAD;
      LOAD:      nxt = STREAM;
      STREAM:    if (accept) nxt = last_in ? WAIT_DONE : FETCH;
      WAIT_DONE: begin
        if (all_done) nxt = DRAIN;
        else if (tmo) nxt = IDLE;
      end
      DRAIN:     if (last_beat) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  // Index, timers, broadcast word and status flags
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      idx         <= '0;
      tcnt        <= '0;
      st_cnt      <= 1'b0;
      bus.x_tdata <= '0;
      err_timeout <= 1'b0;
      layer_done  <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      if (abort) begin
        idx    <= '0;
        st_cnt <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (go) err_timeout <= 1'b0;
          START: begin
            st_cnt <= ~st_cnt;
            idx    <= '0;
          end
          LOAD: bus.x_tdata <= in_rdata;
          STREAM: begin
            if (accept) begin
              if (!last_in) idx <= idx + 1'b1;
              tcnt <= '0;
            end
          end
          WAIT_DONE: begin
            if (!all_done) begin
              if (tmo) err_timeout <= 1'b1;
              else     tcnt <= tcnt + 1'b1;
            end
          end
          DRAIN: if (last_beat) layer_done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  act_out_buffer #(
    .N_NEURONS (N_NEURONS),
    .N_BITS    (N_BITS)
  ) u_buf (
    .clk       (s_axi_aclk),
    .rst_n     (s_axi_aresetn),
    .load      (load),
    .nrn_a     (nrn_a),
    .valid     (drain),
    .m_tready  (bus.m_tready),
    .m_tdata   (bus.m_tdata),
    .m_tvalid  (bus.m_tvalid),
    .m_tlast   (bus.m_tlast),
    .last_beat (last_beat)
  );

endmodule

// File: tb/tb_perceptron_layer_sequencer.sv
// Directed bench for the layer sequencer: 4 inputs, 2 neurons.
// Neuron bank and downstream sink are modelled on the falling edge.
module tb_perceptron_layer_sequencer;

  localparam int N_IN = 4;
  localparam int NN   = 2;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go, abort;
  logic          busy, layer_done, err_timeout;
  logic [2:0]    in_addr;
  logic [DW-1:0] in_rdata;
  logic          nrn_start;
  logic [NN-1:0] nrn_done;
  logic [NN*DW-1:0] nrn_a;
  logic [DW-1:0] mem [8];

  perceptron_layer_sequencer_if #(.DW(DW), .NN(NN)) bus ();

  perceptron_layer_sequencer #(
    .N_INPUTS(N_IN), .N_NEURONS(NN), .N_BITS(DW),
    .ADDR_W(3), .DONE_TIMEOUT(8)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .go(go), .abort(abort), .busy(busy),
    .layer_done(layer_done), .err_timeout(err_timeout),
    .in_addr(in_addr), .in_rdata(in_rdata),
    .nrn_start(nrn_start), .nrn_done(nrn_done),
    .nrn_a(nrn_a), .bus(bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) in_rdata <= mem[in_addr];

  int n_cmp = 0;
  int n_err = 0;

  int cfg_selem, cfg_xstall, cfg_mstall;
  bit cfg_nodone;
  int xstall_left, mstall_left;
  int nacc, dcnt;
  int nx, no, ld_cnt, mv_cnt, start_cyc;
  int xs_cnt, xs_chg, ms_cnt, ms_chg;
  logic [DW-1:0] xs_data, ms_data;
  logic [DW-1:0] xlog [16];
  logic [DW-1:0] olog [8];
  logic          olast [8];

  // bank and sink model: decide readiness for the coming edge, log beats
  always @(negedge clk) begin
    if (nrn_start) begin
      start_cyc++;
      nacc = 0;
      dcnt = 0;
      nrn_done = '0;
    end
    bus.x_tready = '1;
    if (bus.x_tvalid) begin
      if (nacc == cfg_selem && xstall_left > 0) begin
        xstall_left--;
        bus.x_tready = 2'b01;
        if (xs_cnt > 0 && bus.x_tdata !== xs_data) xs_chg++;
        xs_data = bus.x_tdata;
        xs_cnt++;
      end else begin
        if (nx < 16) xlog[nx] = bus.x_tdata;
        nx++;
        nacc++;
        if (nacc == N_IN) dcnt = 3;
      end
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0 && !cfg_nodone) nrn_done = '1;
    end
    bus.m_tready = 1'b1;
    if (bus.m_tvalid) begin
      mv_cnt++;
      if (no == 0 && mstall_left > 0) begin
        mstall_left--;
        bus.m_tready = 1'b0;
        if (ms_cnt > 0 && bus.m_tdata !== ms_data) ms_chg++;
        ms_data = bus.m_tdata;
        ms_cnt++;
      end else begin
        if (no < 8) begin
          olog[no]  = bus.m_tdata;
          olast[no] = bus.m_tlast;
        end
        no++;
      end
    end
    if (layer_done) ld_cnt++;
  end

  typedef struct packed {
    logic [3:0][DW-1:0] x;
    logic [1:0][DW-1:0] a;
    logic [7:0]         xstall;
    logic [7:0]         mstall;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_log();
    nx = 0; no = 0; ld_cnt = 0; mv_cnt = 0; start_cyc = 0;
    xs_cnt = 0; xs_chg = 0; xs_data = '0;
    ms_cnt = 0; ms_chg = 0; ms_data = '0;
    xstall_left = cfg_xstall;
    mstall_left = cfg_mstall;
  endtask

  task automatic set_vec(input int k);
    for (int j = 0; j < N_IN; j++) mem[j] = vt[k].x[j];
    nrn_a = {vt[k].a[1], vt[k].a[0]};
  endtask

  task automatic pulse_go();
    go = 1'b1;
    step(1);
    go = 1'b0;
  endtask

  task automatic wait_ld(input int lim);
    int c;
    c = 0;
    while (ld_cnt == 0 && c < lim) begin
      step(1);
      c++;
    end
    chk("layer_done_seen", 32'(ld_cnt != 0), 1);
  endtask

  task automatic run_layer(input int k);
    set_vec(k);
    cfg_selem  = 1;
    cfg_xstall = int'(vt[k].xstall);
    cfg_mstall = int'(vt[k].mstall);
    cfg_nodone = 1'b0;
    clear_log();
    pulse_go();
    wait_ld(300);
    step(2);
    for (int j = 0; j < N_IN; j++)
      chk($sformatf("v%0d_x%0d", k, j), xlog[j], vt[k].x[j]);
    chk($sformatf("v%0d_accepts", k), nx, N_IN);
    chk($sformatf("v%0d_start_cyc", k), start_cyc, 2);
    chk($sformatf("v%0d_beats", k), no, 2);
    chk($sformatf("v%0d_o0", k), olog[0], vt[k].a[0]);
    chk($sformatf("v%0d_o1", k), olog[1], vt[k].a[1]);
    chk($sformatf("v%0d_last0", k), 32'(olast[0]), 0);
    chk($sformatf("v%0d_last1", k), 32'(olast[1]), 1);
    chk($sformatf("v%0d_ld_pulses", k), ld_cnt, 1);
    chk($sformatf("v%0d_busy_after", k), 32'(busy), 0);
    chk($sformatf("v%0d_mv_cycles", k), mv_cnt,
        2 + int'(vt[k].mstall));
    chk($sformatf("v%0d_xstall_cyc", k), xs_cnt, int'(vt[k].xstall));
    if (vt[k].xstall > 0) begin
      chk($sformatf("v%0d_xstall_data", k), xs_data, vt[k].x[1]);
      chk($sformatf("v%0d_xstall_chg", k), xs_chg, 0);
    end
    chk($sformatf("v%0d_mstall_cyc", k), ms_cnt, int'(vt[k].mstall));
    if (vt[k].mstall > 0) begin
      chk($sformatf("v%0d_mstall_data", k), ms_data, vt[k].a[0]);
      chk($sformatf("v%0d_mstall_chg", k), ms_chg, 0);
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0; go = 1'b0; abort = 1'b0;
    nrn_a = '0; nrn_done = '0;
    cfg_selem = 1; cfg_xstall = 0; cfg_mstall = 0; cfg_nodone = 1'b0;
    nacc = 0; dcnt = 0;
    for (int j = 0; j < 8; j++) mem[j] = 32'(j + 1);
    clear_log();

    vt[0] = '{x: {32'd4, 32'd3, 32'd2, 32'd1},
              a: {32'h20, 32'h10}, xstall: 8'd0, mstall: 8'd0};
    vt[1] = '{x: {32'd4, 32'd3, 32'd2, 32'd1},
              a: {32'h20, 32'h10}, xstall: 8'd5, mstall: 8'd0};
    vt[2] = '{x: {32'd4, 32'd3, 32'd2, 32'd1},
              a: {32'h20, 32'h10}, xstall: 8'd0, mstall: 8'd3};
    vt[3] = '{x: {32'h7, 32'hFFFF_FFFF, 32'h1234_5678, 32'hA5A5_A5A5},
              a: {32'h1, 32'hDEAD_BEEF}, xstall: 8'd2, mstall: 8'd1};

    step(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(nrn_start), 0);
    chk("rst_xvalid", 32'(bus.x_tvalid), 0);
    chk("rst_xdata", bus.x_tdata, 0);
    chk("rst_mvalid", 32'(bus.m_tvalid), 0);
    chk("rst_mdata", bus.m_tdata, 0);
    chk("rst_mlast", 32'(bus.m_tlast), 0);
    chk("rst_ld", 32'(layer_done), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_addr", 32'(in_addr), 0);
    rst_n = 1'b1;
    step(2);

    for (int k = 0; k < 4; k++) run_layer(k);

    // timeout: bank never completes
    set_vec(0);
    cfg_xstall = 0; cfg_mstall = 0; cfg_nodone = 1'b1;
    clear_log();
    pulse_go();
    c = 0;
    while (nx < N_IN && c < 100) begin
      step(1);
      c++;
    end
    chk("to_accepts", nx, N_IN);
    step(7);
    chk("to_err_early", 32'(err_timeout), 0);
    chk("to_busy_wait", 32'(busy), 1);
    step(1);
    chk("to_err_set", 32'(err_timeout), 1);
    chk("to_busy_idle", 32'(busy), 0);
    step(3);
    chk("to_no_mvalid", mv_cnt, 0);
    chk("to_no_ld", ld_cnt, 0);
    chk("to_err_sticky", 32'(err_timeout), 1);

    // go together with abort in IDLE: stay idle, flag untouched
    go = 1'b1; abort = 1'b1;
    step(1);
    go = 1'b0; abort = 1'b0;
    chk("goab_busy", 32'(busy), 0);
    chk("goab_err", 32'(err_timeout), 1);
    step(1);
    chk("goab_start", 32'(nrn_start), 0);

    // next go clears the flag and completes a layer
    cfg_nodone = 1'b0;
    clear_log();
    pulse_go();
    chk("go_clr_err", 32'(err_timeout), 0);
    chk("go_busy", 32'(busy), 1);
    wait_ld(200);
    step(2);
    chk("to_rerun_o0", olog[0], 32'h10);
    chk("to_rerun_o1", olog[1], 32'h20);

    // go-to-valid latency, then abort while element 2 is stalled
    cfg_selem = 2; cfg_xstall = 20;
    clear_log();
    pulse_go();
    chk("lat_start0", 32'(nrn_start), 1);
    step(1);
    chk("lat_start1", 32'(nrn_start), 1);
    step(1);
    chk("lat_fetch_start", 32'(nrn_start), 0);
    chk("lat_fetch_addr", 32'(in_addr), 0);
    step(1);
    chk("lat_load_valid", 32'(bus.x_tvalid), 0);
    step(1);
    chk("lat_valid", 32'(bus.x_tvalid), 1);
    chk("lat_data", bus.x_tdata, 32'd1);
    c = 0;
    while (!(nx == 2 && bus.x_tvalid) && c < 100) begin
      step(1);
      c++;
    end
    chk("ab_idx2_data", bus.x_tdata, 32'd3);
    chk("ab_idx2_addr", 32'(in_addr), 2);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("ab_xvalid", 32'(bus.x_tvalid), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_addr", 32'(in_addr), 0);
    chk("ab_start", 32'(nrn_start), 0);
    step(3);
    chk("ab_no_ld", ld_cnt, 0);
    chk("ab_no_mvalid", mv_cnt, 0);

    cfg_selem = 1; cfg_xstall = 0;
    clear_log();
    pulse_go();
    chk("ab_re_start", 32'(nrn_start), 1);
    step(2);
    chk("ab_re_addr", 32'(in_addr), 0);
    wait_ld(200);
    step(2);
    chk("ab_re_starts", start_cyc, 2);
    chk("ab_re_accepts", nx, N_IN);
    chk("ab_re_x0", xlog[0], 32'd1);
    chk("ab_re_x3", xlog[3], 32'd4);
    chk("ab_re_o1", olog[1], 32'h20);

    // asynchronous reset while a beat is stalled in DRAIN
    cfg_mstall = 4;
    clear_log();
    pulse_go();
    c = 0;
    while (!bus.m_tvalid && c < 200) begin
      step(1);
      c++;
    end
    chk("rd_in_drain", 32'(bus.m_tvalid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rd_mvalid", 32'(bus.m_tvalid), 0);
    chk("rd_mdata", bus.m_tdata, 0);
    chk("rd_mlast", 32'(bus.m_tlast), 0);
    chk("rd_busy", 32'(busy), 0);
    chk("rd_addr", 32'(in_addr), 0);
    chk("rd_xdata", bus.x_tdata, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("rd_no_ld", ld_cnt, 0);
    run_layer(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
